// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit : word-addressed PC register and instruction fetch sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_fetch_unit #(
  parameter int unsigned PROG_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] estado_pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DELIVER = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [31:0] LIMIT = 32'(PROG_WORDS);

  state_t      state;
  logic [31:0] pc_inc;

  assign pc_inc    = estado_pc + 32'd1;
  assign imem_addr = estado_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      estado_pc   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ, DELIVER: begin
          if (branch_taken) begin
            // Redirect wins over stall and discards any returning data.
            estado_pc   <= branch_target;
            instr_valid <= 1'b0;
            if (branch_target < LIMIT) begin
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              state    <= HALT;
              imem_req <= 1'b0;
              halted   <= 1'b1;
            end
          end else if (state == REQ) begin
            if (imem_ready) begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= DELIVER;
              imem_req    <= 1'b0;
            end
          end else if (!stall) begin
            instr_valid <= 1'b0;
            // Running off the end keeps the PC on the last valid word.
            if (pc_inc < LIMIT) begin
              estado_pc <= pc_inc;
              state     <= REQ;
              imem_req  <= 1'b1;
            end else begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        HALT: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit : vector table with scoreboard queue for pc_fetch_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, branch_taken, stall, imem_ready;
  logic [31:0] branch_target;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid, halted;
  logic [31:0] imem_addr, estado_pc, instr;

  always #5 clock = ~clock;

  // Memory returns address*16 at whatever address is presented.
  assign imem_rdata = imem_addr << 4;

  pc_fetch_unit #(.PROG_WORDS(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .estado_pc     (estado_pc),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .halted        (halted)
  );

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] tgt;
    logic        stl;
    logic        rdy;
    logic [31:0] pc;
    logic        req;
    logic        val;
    logic [31:0] ins;
    logic        hlt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   applied = 0;
  int   miscompares = 0;

  function automatic vec_t v(input logic rst, input logic br, input logic [31:0] tgt,
                             input logic stl, input logic rdy, input logic [31:0] pc,
                             input logic req, input logic val, input logic [31:0] ins,
                             input logic hlt);
    vec_t t;
    t.rst = rst; t.br = br; t.tgt = tgt; t.stl = stl; t.rdy = rdy;
    t.pc = pc; t.req = req; t.val = val; t.ins = ins; t.hlt = hlt;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic step(input vec_t t);
    vec_t e;
    @(negedge clock);
    reset         = t.rst;
    branch_taken  = t.br;
    branch_target = t.tgt;
    stall         = t.stl;
    imem_ready    = t.rdy;
    sb.push_back(t);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("estado_pc",   applied, estado_pc,          e.pc);
    chk("imem_addr",   applied, imem_addr,          e.pc);
    chk("imem_req",    applied, 32'(imem_req),      32'(e.req));
    chk("instr_valid", applied, 32'(instr_valid),   32'(e.val));
    chk("instr",       applied, instr,              e.ins);
    chk("halted",      applied, 32'(halted),        32'(e.hlt));
    applied++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; branch_taken = 1'b0; branch_target = '0; stall = 1'b0; imem_ready = 1'b0;

    // reset with memory claiming ready: everything zero
    step(v(1,0,0,0,1, 0,0,0,0,0));
    step(v(1,0,0,0,1, 0,0,0,0,0));

    //              rst br tgt stl rdy  pc req val ins  hlt
    tbl.push_back(v(0, 0, 0,  0,  0,   0, 1,  0, 0,    0)); // IDLE->REQ
    tbl.push_back(v(0, 0, 0,  0,  1,   0, 0,  1, 0,    0));
    tbl.push_back(v(0, 0, 0,  0,  0,   1, 1,  0, 0,    0));
    tbl.push_back(v(0, 0, 0,  0,  1,   1, 0,  1, 'h10, 0));
    tbl.push_back(v(0, 0, 0,  0,  0,   2, 1,  0, 'h10, 0));
    tbl.push_back(v(0, 0, 0,  0,  0,   2, 1,  0, 'h10, 0)); // 3 wait states
    tbl.push_back(v(0, 0, 0,  0,  0,   2, 1,  0, 'h10, 0));
    tbl.push_back(v(0, 0, 0,  0,  0,   2, 1,  0, 'h10, 0));
    tbl.push_back(v(0, 0, 0,  0,  1,   2, 0,  1, 'h20, 0));
    tbl.push_back(v(0, 0, 0,  0,  0,   3, 1,  0, 'h20, 0));
    tbl.push_back(v(0, 0, 0,  0,  1,   3, 0,  1, 'h30, 0));
    tbl.push_back(v(0, 0, 0,  1,  0,   3, 0,  1, 'h30, 0)); // 4-cycle stall
    tbl.push_back(v(0, 0, 0,  1,  1,   3, 0,  1, 'h30, 0));
    tbl.push_back(v(0, 0, 0,  1,  0,   3, 0,  1, 'h30, 0));
    tbl.push_back(v(0, 0, 0,  1,  0,   3, 0,  1, 'h30, 0));
    tbl.push_back(v(0, 0, 0,  0,  0,   4, 1,  0, 'h30, 0));
    tbl.push_back(v(0, 0, 0,  0,  1,   4, 0,  1, 'h40, 0));
    tbl.push_back(v(0, 0, 0,  0,  0,   5, 1,  0, 'h40, 0));
    tbl.push_back(v(0, 0, 0,  0,  1,   5, 0,  1, 'h50, 0));
    tbl.push_back(v(0, 1, 1,  1,  0,   1, 1,  0, 'h50, 0)); // branch in DELIVER
    tbl.push_back(v(0, 1, 3,  0,  1,   3, 1,  0, 'h50, 0)); // branch in REQ, data dropped
    tbl.push_back(v(0, 0, 0,  0,  1,   3, 0,  1, 'h30, 0));
    tbl.push_back(v(0, 0, 0,  0,  0,   4, 1,  0, 'h30, 0));
    tbl.push_back(v(0, 0, 0,  0,  1,   4, 0,  1, 'h40, 0));
    tbl.push_back(v(0, 0, 0,  0,  0,   5, 1,  0, 'h40, 0));
    tbl.push_back(v(0, 0, 0,  0,  1,   5, 0,  1, 'h50, 0));
    tbl.push_back(v(0, 0, 0,  0,  0,   6, 1,  0, 'h50, 0));
    tbl.push_back(v(0, 0, 0,  0,  1,   6, 0,  1, 'h60, 0));
    tbl.push_back(v(0, 0, 0,  0,  0,   7, 1,  0, 'h60, 0));
    tbl.push_back(v(0, 0, 0,  0,  1,   7, 0,  1, 'h70, 0));
    tbl.push_back(v(0, 0, 0,  0,  0,   7, 0,  0, 'h70, 1)); // end of program
    tbl.push_back(v(0, 1, 2,  0,  1,   7, 0,  0, 'h70, 1)); // branch in HALT ignored

    foreach (tbl[i]) step(tbl[i]);

    // reset out of HALT, branch in IDLE ignored, then out-of-range branch at PC=2
    step(v(1,0,0,0,1, 0,0,0,0,0));
    step(v(0,1,5,0,0, 0,1,0,0,0));
    step(v(0,0,0,0,1, 0,0,1,0,0));
    step(v(0,0,0,0,0, 1,1,0,0,0));
    step(v(0,0,0,0,1, 1,0,1,'h10,0));
    step(v(0,0,0,0,0, 2,1,0,'h10,0));
    step(v(0,1,40,0,0, 40,0,0,'h10,1));
    step(v(0,0,0,0,1, 40,0,0,'h10,1));

    // reset asserted in REQ while memory answers
    step(v(1,0,0,0,0, 0,0,0,0,0));
    step(v(0,0,0,0,0, 0,1,0,0,0));
    step(v(1,0,0,0,1, 0,0,0,0,0));
    step(v(0,0,0,0,1, 0,1,0,0,0));
    step(v(0,0,0,0,1, 0,0,1,0,0));

    // branch to the top of the address space halts
    step(v(0,1,32'hFFFF_FFFF,0,0, 32'hFFFF_FFFF,0,0,0,1));

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
